// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared types and constants for the async FIFO read-side stream.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } fifo_obuf_state_t;

    localparam int STALL_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/fifo_rd_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_stream_if
// Description : Read-pointer/RAM handshake plus valid/ready output stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_rd_stream_if #(
    parameter int DATAWIDTH = 8
) ();

    logic                 rempty;
    logic                 rinc;
    logic                 ren;
    logic [DATAWIDTH-1:0] rdata;
    logic                 m_valid;
    logic [DATAWIDTH-1:0] m_data;
    logic                 m_ready;

    modport master (
        input  rempty, rdata, m_ready,
        output rinc, ren, m_valid, m_data
    );

    modport slave (
        output rempty, rdata, m_ready,
        input  rinc, ren, m_valid, m_data
    );

endinterface
`default_nettype wire

// File: rtl/fifo_obuf.sv
`default_nettype none
// ============================================================================
// Module      : fifo_obuf
// Description : Two-entry (head + skid) output buffer with registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_obuf
    import fifo_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic                 i_pending,
    input  logic [DATAWIDTH-1:0] i_rdata,
    input  logic                 i_m_ready,
    output logic                 o_m_valid,
    output logic [DATAWIDTH-1:0] o_m_data,
    output logic [1:0]           o_occ
);

    fifo_obuf_state_t     state_q, state_d;
    logic [DATAWIDTH-1:0] head_q, head_d;
    logic [DATAWIDTH-1:0] skid_q, skid_d;
    logic                 valid_q, valid_d;
    logic                 w_pop;

    assign w_pop = valid_q & i_m_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (i_pending) begin
                    head_d  = i_rdata;
                    state_d = ONE;
                end
            end
            ONE: begin
                case ({i_pending, w_pop})
                    2'b01: state_d = EMPTY;
                    2'b10: begin
                        skid_d  = i_rdata;
                        state_d = TWO;
                    end
                    2'b11: head_d = i_rdata;
                    default: state_d = ONE;
                endcase
            end
            TWO: begin
                // Skid always advances on a pop, so a new word lands in the skid slot.
                if (w_pop) begin
                    head_d  = skid_q;
                    state_d = ONE;
                    if (i_pending) begin
                        skid_d  = i_rdata;
                        state_d = TWO;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
        valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
        end
    end

    assign o_m_valid = valid_q;
    assign o_m_data  = head_q;
    assign o_occ     = state_q;

    a_no_overflow: assert property (@(posedge rclk) disable iff (!rrst_n)
        !(state_q == TWO && i_pending && !w_pop));

endmodule
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_stream
// Description : Async-FIFO read-side stage: issues RAM reads and presents a
//               registered FWFT valid/ready stream. Optional stall counter
//               enabled by FIFO_RD_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 4
) (
    input  logic                   rclk,
    input  logic                   rrst_n,
    fifo_rd_stream_if.master       bus
`ifdef FIFO_RD_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    logic [1:0] w_occ;
    logic       w_pop;
    logic [2:0] w_load;
    logic [2:0] w_limit;
    logic       w_rinc;
    logic       pending_q, pending_d;

    // The counter must be able to outrun one full FIFO worth of stalls.
    if (ADDRWIDTH >= STALL_CNT_W) begin : g_cnt_w_check
        $error("fifo_rd_stream: ADDRWIDTH too large for stall counter");
    end

    assign w_pop   = bus.m_valid & bus.m_ready;
    assign w_load  = {1'b0, w_occ} + {2'b00, pending_q};
    // occ + pending - pop < 2, rearranged to avoid unsigned underflow
    assign w_limit = 3'd2 + {2'b00, w_pop};
    assign w_rinc  = rrst_n & ~bus.rempty & (w_load < w_limit);

    assign bus.rinc = w_rinc;
    assign bus.ren  = w_rinc & ~bus.rempty;

    always_comb begin
        pending_d = bus.ren;
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

    fifo_obuf #(
        .DATAWIDTH (DATAWIDTH)
    ) u_obuf (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .i_pending (pending_q),
        .i_rdata   (bus.rdata),
        .i_m_ready (bus.m_ready),
        .o_m_valid (bus.m_valid),
        .o_m_data  (bus.m_data),
        .o_occ     (w_occ)
    );

`ifdef FIFO_RD_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.m_valid && !bus.m_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_stream
// Description : Scoreboard bench for fifo_rd_stream with a FIFO/RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream;

    localparam int DW = 8;

    logic rclk   = 1'b0;
    logic rrst_n = 1'b0;

    always #5 rclk = ~rclk;

    fifo_rd_stream_if #(.DATAWIDTH(DW)) bus ();

`ifdef FIFO_RD_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    fifo_rd_stream #(
        .DATAWIDTH (DW),
        .ADDRWIDTH (4)
    ) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus)
`ifdef FIFO_RD_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    logic [DW-1:0] mem [0:255];
    int            rd_ptr = 0;
    int            wr_n   = 0;
    logic          ren_s;
    logic [DW-1:0] sb [$];
    int            n_vec = 0;
    int            n_err = 0;
    int            ren_total = 0;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] hold_data = '0;
    int            r0;

    assign bus.rempty = (rd_ptr == wr_n);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] d);
        mem[wr_n[7:0]] = d;
        wr_n++;
        sb.push_back(d);
    endtask

    task automatic flush();
        rd_ptr = 0;
        wr_n   = 0;
        sb.delete();
    endtask

    task automatic tick();
        @(posedge rclk);
        #2;
    endtask

    task automatic sample();
        @(negedge rclk);
        #1;
    endtask

    task automatic wait_valid(input int max);
        for (int i = 0; i < max && !bus.m_valid; i++) begin
            tick();
            sample();
        end
        chk("valid_seen", 32'(bus.m_valid), 32'd1);
    endtask

    task automatic drain(input int max);
        for (int i = 0; i < max && sb.size() != 0; i++) begin
            tick();
            sample();
        end
        chk("drain_sb_size", 32'(sb.size()), 32'd0);
    endtask

    // Synchronous-read RAM and read pointer: one-cycle latency after ren.
    initial begin
        forever begin
            @(negedge rclk);
            ren_s = bus.ren;
            @(posedge rclk);
            #1;
            if (ren_s) begin
                bus.rdata = mem[rd_ptr[7:0]];
                rd_ptr++;
            end
        end
    end

    always @(negedge rclk) begin
        if (rrst_n) begin
            if (hold_prev) begin
                chk("hold_valid", 32'(bus.m_valid), 32'd1);
                chk("hold_data", 32'(bus.m_data), 32'(hold_data));
            end
            if (bus.m_valid && bus.m_ready) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    chk("stream_data", 32'(bus.m_data), 32'(sb.pop_front()));
                end
            end
            if (bus.ren) ren_total++;
            hold_prev = bus.m_valid & ~bus.m_ready;
            hold_data = bus.m_data;
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.m_ready = 1'b0;
        bus.rdata   = '0;

        // Reset with words waiting: nothing may issue.
        push(8'h11);
        push(8'h22);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            sample();
            chk("rst_rinc", 32'(bus.rinc), 32'd0);
            chk("rst_ren", 32'(bus.ren), 32'd0);
            chk("rst_valid", 32'(bus.m_valid), 32'd0);
        end
        chk("rst_data", 32'(bus.m_data), 32'd0);
        tick();
        rrst_n = 1'b1;
        sample();
        chk("ren_after_rst", 32'(bus.ren), 32'd1);
        drain(20);
        tick();
        sample();

        // Single word latency.
        tick();
        push(8'hA5);
        sample();
        chk("sw_ren_c0", 32'(bus.ren), 32'd1);
        chk("sw_valid_c0", 32'(bus.m_valid), 32'd0);
        tick();
        sample();
        chk("sw_valid_c1", 32'(bus.m_valid), 32'd0);
        tick();
        sample();
        chk("sw_valid_c2", 32'(bus.m_valid), 32'd1);
        chk("sw_data_c2", 32'(bus.m_data), 32'hA5);
        tick();
        sample();
        chk("sw_valid_c3", 32'(bus.m_valid), 32'd0);

        // Streaming: 16 back-to-back words.
        tick();
        for (int i = 0; i < 16; i++) push(8'(i));
        sample();
        wait_valid(5);
        for (int k = 0; k < 16; k++) begin
            chk("stream_valid", 32'(bus.m_valid), 32'd1);
            tick();
            sample();
        end
        chk("stream_end_valid", 32'(bus.m_valid), 32'd0);
        chk("stream_sb_size", 32'(sb.size()), 32'd0);

        // Backpressure with a full FIFO.
        tick();
        bus.m_ready = 1'b0;
        r0 = ren_total;
        for (int i = 0; i < 16; i++) push(8'h30 + 8'(i));
        for (int i = 0; i < 10; i++) begin
            sample();
            tick();
        end
        sample();
        chk("bp_ren_pulses", 32'(ren_total - r0), 32'd2);
        chk("bp_rinc", 32'(bus.rinc), 32'd0);
        chk("bp_valid", 32'(bus.m_valid), 32'd1);
        chk("bp_head", 32'(bus.m_data), 32'h30);
        tick();
        bus.m_ready = 1'b1;
        drain(40);
        tick();
        sample();
        chk("bp_end_valid", 32'(bus.m_valid), 32'd0);

        // FIFO empties right after the last issue.
        r0 = ren_total;
        tick();
        push(8'h77);
        push(8'h88);
        for (int i = 0; i < 8; i++) begin
            sample();
            tick();
        end
        sample();
        chk("me_ren_pulses", 32'(ren_total - r0), 32'd2);
        chk("me_valid", 32'(bus.m_valid), 32'd0);
        chk("me_ren", 32'(bus.ren), 32'd0);
        chk("me_sb_size", 32'(sb.size()), 32'd0);

        // Reset mid-operation discards buffered and in-flight words.
        tick();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
        for (int i = 0; i < 4; i++) begin
            sample();
            tick();
        end
        rrst_n = 1'b0;
        flush();
        sample();
        tick();
        sample();
        chk("mr_valid", 32'(bus.m_valid), 32'd0);
        chk("mr_data", 32'(bus.m_data), 32'd0);
        chk("mr_ren", 32'(bus.ren), 32'd0);
`ifdef FIFO_RD_STALL_CNT_EN
        chk("mr_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        tick();
        rrst_n = 1'b1;
        bus.m_ready = 1'b1;
        sample();
        chk("mr_ren_after", 32'(bus.ren), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            sample();
        end
        chk("mr_no_stale", 32'(bus.m_valid), 32'd0);

`ifdef FIFO_RD_STALL_CNT_EN
        // Stall counter counts held cycles and saturates.
        tick();
        bus.m_ready = 1'b0;
        push(8'h5A);
        sample();
        wait_valid(5);
        chk("sc_start", 32'(stall_cnt), 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            sample();
        end
        chk("sc_five", 32'(stall_cnt), 32'd5);
        for (int k = 0; k < 70000; k++) tick();
        sample();
        chk("sc_sat", 32'(stall_cnt), 32'hFFFF);
        tick();
        rrst_n = 1'b0;
        flush();
        tick();
        sample();
        chk("sc_rst", 32'(stall_cnt), 32'd0);
        tick();
        rrst_n = 1'b1;
        bus.m_ready = 1'b1;
        sample();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
